// File: rtl/sha_pkg.sv
// Shared constants and types for the SHA-2 message build/strip blocks.
package sha_pkg;

    localparam int BLOCK_W     = 512;
    localparam int LEN_W       = 64;
    localparam int PAD_LEN_OFF = 64;               // length-field width added before block rounding
    localparam int SPILL_THR   = BLOCK_W - LEN_W;  // 448: marker spills into the previous block
    localparam int CNT_W       = 55;
    localparam int R_W         = 9;                // log2(BLOCK_W)

    typedef enum logic [1:0] {
        EMPTY,
        HOLD,
        DRAIN,
        LEN
    } strip_state_t;

endpackage

// File: rtl/block_tail_mask.sv
// Keeps the top r bits of a block and reports the padding marker at bit 511-r.
// Purely combinational.
module block_tail_mask
    import sha_pkg::*;
(
    input  logic [R_W-1:0]     r,
    input  logic [BLOCK_W-1:0] blk,
    output logic [BLOCK_W-1:0] masked,
    output logic               marker
);

    logic [BLOCK_W-1:0] keep;
    logic [R_W-1:0]     idx;

    always_comb begin
        keep   = ~({BLOCK_W{1'b1}} >> r);
        masked = blk & keep;
        idx    = R_W'(BLOCK_W - 1) - r;
        marker = blk[idx];
    end

endmodule

// File: rtl/message_strip.sv
// Strips SHA-2 padding from a padded block stream, emitting message blocks and the bit length.
// One held block of latency; data_out backpressure stalls the input without loss.
module message_strip
    import sha_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [BLOCK_W-1:0] data_in,
    input  logic               data_in_last,
    input  logic               data_in_valid,
    output logic               data_in_ready,
    output logic [BLOCK_W-1:0] data_out,
    output logic               data_out_last,
    output logic               data_out_valid,
    input  logic               data_out_ready,
    output logic [LEN_W-1:0]   len_out,
    output logic               len_err,
    output logic               len_valid,
    input  logic               len_ready
);

    localparam int EN_W = LEN_W - R_W + 2;

    strip_state_t state_q, state_d;

    logic [BLOCK_W-1:0] hold_q;
    logic [BLOCK_W-1:0] pend_q;
    logic               pend_vld;
    logic [CNT_W-1:0]   cnt_q;

    logic               accept, out_xfer, len_xfer;
    logic [LEN_W-1:0]   len_in;
    logic [R_W-1:0]     r;
    logic [LEN_W:0]     len_pad;
    logic [EN_W-1:0]    exp_n;
    logic [CNT_W-1:0]   n_total;
    logic               cnt_sat, spill, hold_vld, err, has_beat;
    logic [BLOCK_W-1:0] mask_src, masked;
    logic               marker;
    logic [BLOCK_W-1:0] ev_dat;
    logic               ev_last, ev_pend;

    // The marker lives in the held block once it spills past the length field.
    block_tail_mask u_mask (
        .r      (r),
        .blk    (mask_src),
        .masked (masked),
        .marker (marker)
    );

    always_comb begin
        len_in   = data_in[LEN_W-1:0];
        r        = len_in[R_W-1:0];
        len_pad  = {1'b0, len_in} + (LEN_W + 1)'(PAD_LEN_OFF);
        exp_n    = EN_W'(len_pad >> R_W) + EN_W'(1);
        cnt_sat  = &cnt_q;
        n_total  = cnt_sat ? cnt_q : cnt_q + CNT_W'(1);
        spill    = r >= R_W'(SPILL_THR);
        hold_vld = (state_q == HOLD);
        mask_src = spill ? hold_q : data_in;
        err      = cnt_sat || (EN_W'(n_total) != exp_n) || !marker;
        has_beat = !err && (len_in != '0);

        ev_dat  = masked;
        ev_last = 1'b1;
        ev_pend = 1'b0;
        if (r == '0) begin
            ev_dat = hold_q;
        end else if (!spill && hold_vld) begin
            ev_dat  = hold_q;
            ev_last = 1'b0;
            ev_pend = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= EMPTY;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        data_in_ready = 1'b0;
        case (state_q)
            EMPTY: data_in_ready = 1'b1;
            HOLD:  data_in_ready = !data_out_valid || data_out_ready;
            default: data_in_ready = 1'b0;
        endcase
        if (rst) data_in_ready = 1'b0;
        accept   = data_in_valid && data_in_ready;
        out_xfer = data_out_valid && data_out_ready;
        len_xfer = len_valid && len_ready;

        case (state_q)
            EMPTY, HOLD: begin
                if (accept) begin
                    if (!data_in_last) state_d = HOLD;
                    else if (has_beat) state_d = DRAIN;
                    else               state_d = LEN;
                end
            end
            DRAIN: if (out_xfer && !pend_vld) state_d = LEN;
            LEN:   if (len_xfer) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q         <= '0;
            pend_q         <= '0;
            pend_vld       <= 1'b0;
            cnt_q          <= '0;
            data_out       <= '0;
            data_out_last  <= 1'b0;
            data_out_valid <= 1'b0;
            len_out        <= '0;
            len_err        <= 1'b0;
            len_valid      <= 1'b0;
        end else begin
            if (out_xfer) data_out_valid <= 1'b0;

            if ((state_q == EMPTY || state_q == HOLD) && accept) begin
                if (!data_in_last) begin
                    if (hold_vld) begin
                        data_out       <= hold_q;
                        data_out_last  <= 1'b0;
                        data_out_valid <= 1'b1;
                    end
                    hold_q <= data_in;
                    cnt_q  <= n_total;
                end else begin
                    hold_q  <= '0;
                    len_out <= len_in;
                    len_err <= err;
                    if (has_beat) begin
                        data_out       <= ev_dat;
                        data_out_last  <= ev_last;
                        data_out_valid <= 1'b1;
                        pend_q         <= masked;
                        pend_vld       <= ev_pend;
                    end else begin
                        len_valid <= 1'b1;
                    end
                end
            end

            if (state_q == DRAIN && out_xfer) begin
                if (pend_vld) begin
                    data_out       <= pend_q;
                    data_out_last  <= 1'b1;
                    data_out_valid <= 1'b1;
                    pend_vld       <= 1'b0;
                end else begin
                    len_valid <= 1'b1;
                end
            end

            if (state_q == LEN && len_xfer) begin
                len_valid <= 1'b0;
                cnt_q     <= '0;
            end
        end
    end

endmodule
